// File: rtl/ahb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ahb_pkg                                                          |
// | AHB-Lite transfer codes and the SRAM slave state type.           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package ahb_pkg;

   localparam logic [1:0] c_htrans_idle   = 2'b00;
   localparam logic [1:0] c_htrans_busy   = 2'b01;
   localparam logic [1:0] c_htrans_nonseq = 2'b10;
   localparam logic [1:0] c_htrans_seq    = 2'b11;

   localparam logic [2:0] c_hsize_byte = 3'd0;
   localparam logic [2:0] c_hsize_half = 3'd1;
   localparam logic [2:0] c_hsize_word = 3'd2;

   localparam logic c_hresp_okay  = 1'b0;
   localparam logic c_hresp_error = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } slave_state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_lane_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ahb_lane_decode                                                  |
// | Little-endian byte-lane mask and alignment/size legality check.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ahb_lane_decode
   import ahb_pkg::*;
(
   input  logic [1:0] i_addr_lo,
   input  logic [2:0] i_size,
   output logic [3:0] o_mask,
   output logic       o_illegal
);

   always_comb begin
      o_mask    = 4'b0000;
      o_illegal = 1'b0;
      case (i_size)
         c_hsize_byte: o_mask = 4'b0001 << i_addr_lo;
         c_hsize_half: begin
            o_mask    = 4'b0011 << i_addr_lo;
            o_illegal = i_addr_lo[0];
         end
         c_hsize_word: begin
            o_mask    = 4'b1111;
            o_illegal = (i_addr_lo != 2'b00);
         end
         default: o_illegal = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ahb_sram_slave                                                   |
// | AHB-Lite subordinate fronting a byte-writable word SRAM.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int unsigned DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 1
)(
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP
);

   localparam int unsigned c_idx_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [32:0] c_limit     = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
   localparam logic [1:0]  c_wait_load = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

   slave_state_t         r_state;
   slave_state_t         w_state_nxt;
   logic [1:0]           r_cnt;
   logic [1:0]           w_cnt_nxt;
   logic                 r_active;
   logic                 w_active_nxt;
   logic                 r_write;
   logic [3:0]           r_mask;
   logic [c_idx_w-1:0]   r_idx;
   logic [31:0]          r_mem [DEPTH];

   logic                 w_req;
   logic                 w_in_range;
   logic                 w_lane_illegal;
   logic [3:0]           w_lane_mask;
   logic                 w_err;
   logic                 w_latch;
   logic                 w_complete;
   logic [c_idx_w-1:0]   w_idx;

   ahb_lane_decode u_lane_decode (
      .i_addr_lo (HADDR[1:0]),
      .i_size    (HSIZE),
      .o_mask    (w_lane_mask),
      .o_illegal (w_lane_illegal)
   );

   assign w_req      = HSEL & HREADY & ~((HTRANS == c_htrans_idle) | (HTRANS == c_htrans_busy));
   assign w_in_range = ({1'b0, HADDR} >= {1'b0, BASE_ADDR}) && ({1'b0, HADDR} < c_limit);
   assign w_err      = ~w_in_range | w_lane_illegal;
   assign w_idx      = c_idx_w'((HADDR - BASE_ADDR) >> 2);
   // Completing cycle of an OKAY transfer is an IDLE cycle with a data phase pending.
   assign w_complete = (r_state == ST_IDLE) & r_active;

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_active_nxt = r_active;
      w_latch      = 1'b0;
      HREADYOUT    = 1'b1;
      HRESP        = c_hresp_okay;
      case (r_state)
         ST_WAIT: begin
            HREADYOUT = 1'b0;
            if (r_cnt == 2'd0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 2'd1;
            end
         end
         ST_ERR1: begin
            HREADYOUT   = 1'b0;
            HRESP       = c_hresp_error;
            w_state_nxt = ST_ERR2;
         end
         default: begin
            if (r_state == ST_ERR2) begin
               HRESP = c_hresp_error;
            end
            if (HREADY) begin
               w_state_nxt  = ST_IDLE;
               w_active_nxt = 1'b0;
               if (w_req) begin
                  if (w_err) begin
                     w_state_nxt = ST_ERR1;
                  end else begin
                     w_latch      = 1'b1;
                     w_active_nxt = 1'b1;
                     if (WAIT_STATES != 0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_wait_load;
                     end
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 2'd0;
         r_active <= 1'b0;
         r_write  <= 1'b0;
         r_mask   <= 4'b0000;
         r_idx    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_active <= w_active_nxt;
         if (w_latch) begin
            r_write <= HWRITE;
            r_mask  <= w_lane_mask;
            r_idx   <= w_idx;
         end
      end
   end

   // Array kept free of reset so it maps onto byte-write SRAM.
   always_ff @(posedge HCLK) begin
      if (w_complete && r_write) begin
         for (int b = 0; b < 4; b++) begin
            if (r_mask[b]) begin
               r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
            end
         end
      end
   end

   assign HRDATA = (w_complete && !r_write) ? r_mem[r_idx] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ahb_sram_slave                                                |
// | Directed and random transfers on two slaves (1 and 0 waits).     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_ahb_sram_slave;

   localparam int unsigned D1 = 1024;
   localparam logic [31:0] B1 = 32'h0000_0000;
   localparam int unsigned D0 = 256;
   localparam logic [31:0] B0 = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel;
   logic        which;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic        hsel0, hsel1;
   logic [31:0] rdata0, rdata1;
   logic        ready0, ready1, resp0, resp1;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mdl [logic [32:0]];

   always #5 clk = ~clk;

   assign hsel1 = sel & which;
   assign hsel0 = sel & ~which;

   ahb_sram_slave #(.DEPTH(D1), .BASE_ADDR(B1), .WAIT_STATES(1)) u_dut1 (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ready1),
      .HRDATA(rdata1), .HREADYOUT(ready1), .HRESP(resp1)
   );

   ahb_sram_slave #(.DEPTH(D0), .BASE_ADDR(B0), .WAIT_STATES(0)) u_dut0 (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ready0),
      .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
   );

   function automatic logic cur_ready(logic w);
      return w ? ready1 : ready0;
   endfunction

   function automatic logic cur_resp(logic w);
      return w ? resp1 : resp0;
   endfunction

   function automatic logic [31:0] cur_rdata(logic w);
      return w ? rdata1 : rdata0;
   endfunction

   function automatic bit legal(logic w, logic [31:0] a, logic [2:0] s);
      longint unsigned base = w ? longint'(B1) : longint'(B0);
      longint unsigned lim  = base + 4 * (w ? D1 : D0);
      if (longint'(a) < base || longint'(a) >= lim) return 1'b0;
      if (s > 3'd2) return 1'b0;
      if (s == 3'd1 && (a % 2) != 0) return 1'b0;
      if (s == 3'd2 && (a % 4) != 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void model_write(logic w, logic [31:0] a, logic [2:0] s, logic [31:0] d);
      for (int i = 0; i < (1 << s); i++) begin
         logic [31:0] ba = a + 32'(i);
         int lane = int'(ba % 4);
         mdl[{w, ba}] = d[lane*8 +: 8];
      end
   endfunction

   function automatic logic [31:0] model_word(logic w, logic [31:0] a);
      logic [31:0] r;
      logic [31:0] wa = a - (a % 4);
      for (int i = 0; i < 4; i++) begin
         logic [32:0] k = {w, wa + 32'(i)};
         r[8*i +: 8] = mdl.exists(k) ? mdl[k] : 8'hxx;
      end
      return r;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One isolated transfer: address phase, then data phase until HREADYOUT=1.
   task automatic xfer(logic w, logic wr, logic [31:0] a, logic [2:0] s, logic [31:0] d, string tag);
      bit          ok = legal(w, a, s);
      int          lows = 0;
      logic        first_resp = 1'b0;
      logic [31:0] exp_rd;
      int          exp_lows;
      exp_rd   = (ok && !wr) ? model_word(w, a) : 32'h0;
      exp_lows = ok ? (w ? 1 : 0) : 1;
      @(posedge clk); #1;
      which = w; sel = 1'b1; haddr = a; htrans = 2'b10; hwrite = wr; hsize = s;
      @(posedge clk); #1;
      sel = 1'b0; htrans = 2'b00; hwdata = d;
      while (cur_ready(w) == 1'b0 && lows < 10) begin
         if (lows == 0) first_resp = cur_resp(w);
         lows++;
         @(posedge clk); #1;
      end
      check({tag, " waits"}, 32'(lows), 32'(exp_lows));
      if (lows > 0) check({tag, " resp_first"}, 32'(first_resp), ok ? 32'd0 : 32'd1);
      check({tag, " resp"}, 32'(cur_resp(w)), ok ? 32'd0 : 32'd1);
      check({tag, " rdata"}, cur_rdata(w), exp_rd);
      if (ok && wr) model_write(w, a, s, d);
   endtask

   initial begin
      rst_n = 1'b0; sel = 1'b0; which = 1'b1; haddr = '0; hwdata = '0;
      htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("rst ready1", 32'(ready1), 32'd1);
      check("rst resp1", 32'(resp1), 32'd0);
      check("rst rdata1", rdata1, 32'h0);
      check("rst ready0", 32'(ready0), 32'd1);

      xfer(1, 1, 32'h10, 3'd2, 32'hDEADBEEF, "wr10");
      xfer(1, 0, 32'h10, 3'd2, 32'h0, "rd10");
      check("rd10 value", model_word(1, 32'h10), 32'hDEADBEEF);

      xfer(1, 1, 32'h20, 3'd2, 32'h0, "wr20");
      xfer(1, 1, 32'h21, 3'd0, 32'h0000_1100, "wrb21");
      xfer(1, 1, 32'h22, 3'd1, 32'hAABB_0000, "wrh22");
      xfer(1, 0, 32'h20, 3'd2, 32'h0, "rd20");
      check("rd20 value", model_word(1, 32'h20), 32'hAABB1100);

      xfer(1, 0, 32'h02, 3'd2, 32'h0, "err_mis");
      xfer(1, 0, B1 + 4 * D1, 3'd2, 32'h0, "err_range");

      xfer(1, 1, 32'h00, 3'd2, 32'hCAFEF00D, "wr00");
      xfer(1, 1, 32'h03, 3'd2, 32'h12345678, "err_wr03");
      xfer(1, 0, 32'h00, 3'd2, 32'h0, "rd00");

      // Back-to-back write then read on the zero-wait slave.
      @(posedge clk); #1;
      which = 1'b0; sel = 1'b1; haddr = B0 + 32'h40; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
      @(posedge clk); #1;
      hwdata = 32'h55; hwrite = 1'b0;
      check("b2b wr ready", 32'(ready0), 32'd1);
      check("b2b wr resp", 32'(resp0), 32'd0);
      check("b2b wr rdata", rdata0, 32'h0);
      model_write(0, B0 + 32'h40, 3'd2, 32'h55);
      @(posedge clk); #1;
      sel = 1'b0; htrans = 2'b00;
      check("b2b rd ready", 32'(ready0), 32'd1);
      check("b2b rd rdata", rdata0, model_word(0, B0 + 32'h40));
      xfer(0, 0, B0 - 32'd4, 3'd2, 32'h0, "err_below");

      // Reset during the wait cycle of a write drops it.
      xfer(1, 1, 32'h8, 3'd2, 32'h1, "rst_pre");
      @(posedge clk); #1;
      which = 1'b1; sel = 1'b1; haddr = 32'h8; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
      @(posedge clk); #1;
      sel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
      check("rst in wait", 32'(ready1), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("rst ready", 32'(ready1), 32'd1);
      check("rst resp", 32'(resp1), 32'd0);
      check("rst rdata", rdata1, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      xfer(1, 0, 32'h8, 3'd2, 32'h0, "rst_read");

      for (int w = 0; w < 2; w++) begin
         logic [31:0] base = (w == 1) ? B1 : B0;
         logic [31:0] lim  = base + 4 * ((w == 1) ? D1 : D0);
         for (int i = 0; i < 8; i++) begin
            xfer(w[0], 1, base + 32'h100 + 32'(4 * i), 3'd2, $urandom, "pre");
         end
         for (int i = 0; i < 30; i++) begin
            int          r = $urandom_range(0, 9);
            logic [31:0] a;
            logic [2:0]  s;
            if (r == 0) a = lim + 32'($urandom_range(0, 7));
            else if (r == 1 && w == 0) a = base - 32'($urandom_range(1, 8));
            else a = base + 32'h100 + 32'($urandom_range(0, 31));
            s = ($urandom_range(0, 9) == 0) ? 3'(3 + $urandom_range(0, 4)) : 3'($urandom_range(0, 2));
            xfer(w[0], 1'($urandom_range(0, 1)), a, s, $urandom, $sformatf("rnd%0d_%0d", w, i));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
